// File: rtl/painel_shift_reg.sv
// painel_shift_reg: panel row shift register with load, rotate/fill, auto-scroll prescaler and manual step
module painel_shift_reg #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rotate,
    input  logic             fill_bit,
    input  logic [DIV_W-1:0] step_div,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    output logic [WIDTH-1:0] Q,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [DIV_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic load, shift, in_bit, pos_last;
    always_comb begin
        state_next = stop ? IDLE : (start ? RUN : state);
        load       = mode == 2'b01;
        shift      = mode[1] && (state == RUN ? cnt >= step_div : step);
        in_bit     = rotate ? (mode[0] ? Q[WIDTH-1] : Q[0]) : fill_bit;
        q_next     = mode[0] ? {Q[WIDTH-2:0], in_bit} : {in_bit, Q[WIDTH-1:1]};
        pos_last   = pos == POS_W'(WIDTH - 1);
        // prescaler only counts while staying in RUN; mode 00 freezes it
        cnt_next   = (state != RUN || state_next != RUN || load || shift) ? '0 :
                     mode[1] ? cnt + DIV_W'(1) : cnt;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            Q     <= '0;
            pos   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= state_next == RUN;
            cnt   <= cnt_next;
            wrap  <= !load && shift && pos_last;
            if (load) begin
                Q   <= load_data;
                pos <= '0;
            end else if (shift) begin
                Q   <= q_next;
                pos <= pos_last ? '0 : pos + POS_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_painel_shift_reg.sv
// tb_painel_shift_reg: directed self-checking bench for painel_shift_reg (WIDTH=8)
module tb_painel_shift_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  load_data = '0;
    logic        rotate = 1'b0;
    logic        fill_bit = 1'b0;
    logic [15:0] step_div = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  Q;
    logic [2:0]  pos;
    logic        wrap;
    logic        busy;
    int passed = 0;
    int total = 0;

    localparam logic [7:0] ROT [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    localparam logic [7:0] DRN [8] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

    painel_shift_reg #(.WIDTH(8), .DIV_W(16)) dut (
        .CLK(clk), .RST_N(rst_n), .mode(mode), .load_data(load_data), .rotate(rotate),
        .fill_bit(fill_bit), .step_div(step_div), .start(start), .stop(stop), .step(step),
        .Q(Q), .pos(pos), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (Q !== 8'h00) $display("FAIL reset_q got=%h exp=00", Q); else passed++;
        total++; if (pos !== 3'd0) $display("FAIL reset_pos got=%0d exp=0", pos); else passed++;
        total++; if ({busy, wrap} !== 2'b00) $display("FAIL reset_busy_wrap got=%b exp=00", {busy, wrap}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rotate_scroll();
        mode = 2'b01; load_data = 8'h81;
        tick();
        total++; if (Q !== 8'h81) $display("FAIL rot_load got=%h exp=81", Q); else passed++;
        mode = 2'b11; rotate = 1'b1; step_div = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || Q !== 8'h81) $display("FAIL rot_start busy=%b q=%h exp busy=1 q=81", busy, Q); else passed++;
        for (int k = 1; k <= 8; k++) begin
            tick(); tick();
            total++; if (Q !== ROT[(k+6)%8]) $display("FAIL rot_hold%0d got=%h exp=%h", k, Q, ROT[(k+6)%8]); else passed++;
            tick();
            total++; if (Q !== ROT[k-1]) $display("FAIL rot_shift%0d got=%h exp=%h", k, Q, ROT[k-1]); else passed++;
            total++; if (pos !== 3'(k % 8)) $display("FAIL rot_pos%0d got=%0d exp=%0d", k, pos, k % 8); else passed++;
            total++; if (wrap !== (k == 8)) $display("FAIL rot_wrap%0d got=%b exp=%b", k, wrap, k == 8); else passed++;
        end
        tick();
        total++; if (wrap !== 1'b0) $display("FAIL rot_wrap_clear got=%b exp=0", wrap); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (busy !== 1'b0 || Q !== 8'h81) $display("FAIL rot_stop busy=%b q=%h exp busy=0 q=81", busy, Q); else passed++;
    endtask

    task automatic test_fill_drain();
        mode = 2'b01; load_data = 8'hFF;
        tick();
        mode = 2'b10; rotate = 1'b0; fill_bit = 1'b0; step_div = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (Q !== 8'hFF || busy !== 1'b1) $display("FAIL drain_start q=%h busy=%b exp q=ff busy=1", Q, busy); else passed++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++; if (Q !== DRN[k-1]) $display("FAIL drain_q%0d got=%h exp=%h", k, Q, DRN[k-1]); else passed++;
            total++; if (wrap !== (k == 8)) $display("FAIL drain_wrap%0d got=%b exp=%b", k, wrap, k == 8); else passed++;
        end
    endtask

    task automatic test_start_stop_collision();
        mode = 2'b01; load_data = 8'hA5;
        tick();
        mode = 2'b10; rotate = 1'b1; step_div = 16'd5; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total++; if (busy !== 1'b0 || Q !== 8'hA5) $display("FAIL coll_idle busy=%b q=%h exp busy=0 q=a5", busy, Q); else passed++;
        tick(); tick();
        total++; if (Q !== 8'hA5) $display("FAIL coll_frozen got=%h exp=a5", Q); else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL coll_restart busy=%b exp=1", busy); else passed++;
        repeat (5) tick();
        total++; if (Q !== 8'hA5) $display("FAIL coll_early got=%h exp=a5", Q); else passed++;
        tick();
        total++; if (Q !== 8'hD2 || pos !== 3'd1) $display("FAIL coll_first q=%h pos=%0d exp q=d2 pos=1", Q, pos); else passed++;
    endtask

    task automatic test_async_reset();
        mode = 2'b01; load_data = 8'hA5;
        tick();
        mode = 2'b00;
        tick();
        total++; if (Q !== 8'hA5 || busy !== 1'b1) $display("FAIL ar_pre q=%h busy=%b exp q=a5 busy=1", Q, busy); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (Q !== 8'h00 || pos !== 3'd0 || busy !== 1'b0) $display("FAIL ar_async q=%h pos=%0d busy=%b exp 00/0/0", Q, pos, busy); else passed++;
        #1 rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || Q !== 8'h00) $display("FAIL ar_after q=%h busy=%b exp q=00 busy=0", Q, busy); else passed++;
    endtask

    task automatic test_load_priority();
        mode = 2'b01; load_data = 8'h01;
        tick();
        mode = 2'b11; rotate = 1'b0; fill_bit = 1'b0; step_div = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        total++; if (Q !== 8'h02 || pos !== 3'd1) $display("FAIL lp_shift q=%h pos=%0d exp q=02 pos=1", Q, pos); else passed++;
        repeat (3) tick();
        mode = 2'b01; load_data = 8'h3C;
        tick();
        mode = 2'b11;
        total++; if (Q !== 8'h3C || pos !== 3'd0 || wrap !== 1'b0) $display("FAIL lp_load q=%h pos=%0d wrap=%b exp 3c/0/0", Q, pos, wrap); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL lp_busy got=%b exp=1", busy); else passed++;
        repeat (3) tick();
        total++; if (Q !== 8'h3C) $display("FAIL lp_wait got=%h exp=3c", Q); else passed++;
        tick();
        total++; if (Q !== 8'h78 || pos !== 3'd1) $display("FAIL lp_next q=%h pos=%0d exp q=78 pos=1", Q, pos); else passed++;
    endtask

    task automatic test_manual_step();
        mode = 2'b00; stop = 1'b1;
        tick();
        stop = 1'b0;
        mode = 2'b01; load_data = 8'h01;
        tick();
        mode = 2'b11; rotate = 1'b0; fill_bit = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        total++; if (Q !== 8'h03 || pos !== 3'd1 || busy !== 1'b0) $display("FAIL step_one q=%h pos=%0d busy=%b exp 03/1/0", Q, pos, busy); else passed++;
        tick();
        total++; if (Q !== 8'h03) $display("FAIL step_idle_hold got=%h exp=03", Q); else passed++;
        mode = 2'b00; step = 1'b1;
        tick();
        total++; if (Q !== 8'h03 || pos !== 3'd1) $display("FAIL step_mode00 q=%h pos=%0d exp 03/1", Q, pos); else passed++;
        mode = 2'b11;
        tick(); tick();
        step = 1'b0;
        total++; if (Q !== 8'h0F || pos !== 3'd3) $display("FAIL step_held q=%h pos=%0d exp 0f/3", Q, pos); else passed++;
        step_div = 16'd10; start = 1'b1;
        tick();
        start = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        total++; if (Q !== 8'h0F || busy !== 1'b1) $display("FAIL step_in_run q=%h busy=%b exp 0f/1", Q, busy); else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_scroll();
        test_fill_drain();
        test_start_stop_collision();
        test_async_reset();
        test_load_priority();
        test_manual_step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
